mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the five-stage pipeline, sitting between the EX/MEM boundary and the write-back stage. Accepts one instruction per cycle from EX, performs loads and stores over a request/acknowledge data-memory port, and registers the result (load data, ALU result, destination, write enable) for write-back. It stalls upstream while a memory transaction is outstanding and aborts transactions that exceed a timeout.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles `dmem_req` stays high without `dmem_ack` before abort; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  instruction present from EX.
- `ex_alu_res`  in  32  ALU result, also the memory address.
- `ex_store_data`  in  32  store data.
- `ex_des`  in  32  destination field, passed to WB.
- `ex_register_write`  in  1  instruction writes the register file.
- `ex_mem_read`  in  1  load.
- `ex_mem_write`  in  1  store.
- `stall_out`  out  1  upstream must hold its current instruction.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  1 = write, 0 = read.
- `dmem_addr`  out  32  word address, low two bits always 0.
- `dmem_wdata`  out  32  write data.
- `dmem_rdata`  in  32  read data, valid with `dmem_ack`.
- `dmem_ack`  in  1  transaction complete.
- `wb_valid`  out  1  WB outputs hold a valid instruction.
- `wb_memoryData`  out  32  load data (0 for non-loads).
- `wb_alu_res`  out  32  registered ALU result.
- `wb_des`  out  32  registered destination.
- `wb_register_write`  out  1  registered write enable.
- `mem_err`  out  1  instruction in WB was aborted (timeout or misalignment).

## Operation
- FSM states: IDLE, WAIT. Reset → IDLE.
- IDLE, `ex_valid`=0: WB registers load a bubble (`wb_valid`=0, `wb_register_write`=0, `mem_err`=0); data fields hold their previous values.
- IDLE, `ex_valid`=1, no memory op: WB registers load the EX fields; `wb_memoryData`=0; `mem_err`=0.
- IDLE, `ex_valid`=1, memory op: latch the address, data, des, write-enable and op type internally; register `dmem_req`=1, `dmem_we`=`ex_mem_write`, `dmem_addr`={`ex_alu_res`[31:2],2'b00}; clear the timeout counter; go to WAIT; WB registers load a bubble.
- `ex_mem_read` and `ex_mem_write` both high: treated as a store.
- WAIT: `dmem_req`, `dmem_we`, `dmem_addr` and `dmem_wdata` are held stable. WB outputs a bubble each cycle. EX inputs are ignored.
- WAIT and `dmem_ack`=1: drop `dmem_req`; WB registers load the held instruction. For a load, `wb_memoryData`=`dmem_rdata`; for a store, it is 0. `mem_err`=0. Go to IDLE.
- WAIT, no ack, counter = `TIMEOUT_CYCLES`−1: drop `dmem_req`; WB loads the held instruction with `wb_register_write`=0, `wb_memoryData`=0 and `mem_err`=1. Go to IDLE. Otherwise the counter increments (8-bit, never wraps).
- Ack and timeout in the same cycle: ack wins.
- `dmem_ack` in IDLE is ignored.
- `stall_out` = (state == WAIT), decoded from the state register.

## Timing
- Reset values: every output is 0; state is IDLE; the counter is 0.
- Reset asserted mid-WAIT: `dmem_req` drops asynchronously and the transaction is abandoned.
- Non-memory instruction: one-cycle latency, EX to WB outputs.
- Memory instruction: `dmem_req` rises on the edge after acceptance. WB outputs become valid on the edge after the `dmem_ack` cycle. Minimum latency is 2 cycles (ack in the first WAIT cycle).
- `stall_out` is high for every WAIT cycle, including the ack cycle. The held upstream instruction is accepted in the first IDLE cycle.
- `dmem_req` stays high for at most `TIMEOUT_CYCLES` cycles.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A memory op in IDLE with `ex_alu_res`[1:0]≠0 issues no request and does not enter WAIT.
  - WB loads it with `wb_register_write`=0, `wb_memoryData`=0 and `mem_err`=1 on the next edge.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - Address bits [1:0] are silently ignored and the access proceeds normally.

## Test plan
- Reset, then ALU op (`ex_alu_res`=0x1234, `ex_des`=5, `ex_register_write`=1) → next cycle `wb_valid`=1, `wb_alu_res`=0x1234, `wb_des`=5, `wb_memoryData`=0, `stall_out`=0.
- Load at 0x100; `dmem_ack` held low for 3 cycles, then high with `dmem_rdata`=0xDEADBEEF → `stall_out` high for 4 cycles, `dmem_addr`=0x100 stable throughout, `wb_memoryData`=0xDEADBEEF one cycle after ack.
- Store at 0x200 (`ex_store_data`=0xA5A5A5A5) followed by an ALU op held by the stall → `dmem_we`=1, `dmem_wdata`=0xA5A5A5A5; the ALU op reaches WB one cycle after the store's WB.
- `TIMEOUT_CYCLES`=4, load with no ack → `dmem_req` high for exactly 4 cycles, then `wb_valid`=1, `mem_err`=1, `wb_register_write`=0.
- Assert `rst_n`=0 mid-WAIT → `dmem_req`, `stall_out` and `wb_valid` go 0 immediately; after release the next ALU op passes normally.
- With `MEM_MISALIGN_TRAP_EN`, load at 0x103 → `dmem_req` never rises, next-cycle `mem_err`=1. Without the macro, the same load gives `dmem_addr`=0x100.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage between EX/MEM and write-back.
//   Accepts one instruction per cycle from EX. Non-memory ops reach the WB registers one cycle later.
//   Loads and stores hold the pipeline, using stall_out, until dmem_ack arrives or the timeout fires.
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   ex_*                            instruction fields from EX (valid, alu result/address, store data, des, controls)
//   stall_out                       high while a memory transaction is outstanding; upstream holds its instruction
//   dmem_req/we/addr/wdata          registered request side of the data-memory port
//   dmem_rdata/ack                  response side of the data-memory port
//   wb_*                            registered results for write-back
//   mem_err                         the instruction now in WB was aborted
// Option: define MEM_MISALIGN_TRAP_EN to abort memory ops whose address bits [1:0] are non-zero
//   without issuing a request. When it is undefined, those bits are ignored.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_res,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_des,
  input  logic        ex_register_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_memoryData,
  output logic [31:0] wb_alu_res,
  output logic [31:0] wb_des,
  output logic        wb_register_write,
  output logic        mem_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Final counter value before abort: req is high for exactly TIMEOUT_CYCLES cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] hold_alu_res;
  logic [31:0] hold_des;
  logic        hold_register_write;
  logic        hold_load;

  logic is_mem;
  logic misalign;

  assign is_mem = ex_mem_read | ex_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = (ex_alu_res[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign stall_out = (state == S_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      cnt                 <= 8'd0;
      hold_alu_res        <= 32'd0;
      hold_des            <= 32'd0;
      hold_register_write <= 1'b0;
      hold_load           <= 1'b0;
      dmem_req            <= 1'b0;
      dmem_we             <= 1'b0;
      dmem_addr           <= 32'd0;
      dmem_wdata          <= 32'd0;
      wb_valid            <= 1'b0;
      wb_memoryData       <= 32'd0;
      wb_alu_res          <= 32'd0;
      wb_des              <= 32'd0;
      wb_register_write   <= 1'b0;
      mem_err             <= 1'b0;
    end else begin
      // Default every cycle is a bubble; the data fields keep their old values.
      wb_valid          <= 1'b0;
      wb_register_write <= 1'b0;
      mem_err           <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              wb_valid          <= 1'b1;
              wb_alu_res        <= ex_alu_res;
              wb_des            <= ex_des;
              wb_register_write <= ex_register_write;
              wb_memoryData     <= 32'd0;
            end else if (misalign) begin
              wb_valid      <= 1'b1;
              wb_alu_res    <= ex_alu_res;
              wb_des        <= ex_des;
              wb_memoryData <= 32'd0;
              mem_err       <= 1'b1;
            end else begin
              // A store takes priority when read and write are both set.
              hold_alu_res        <= ex_alu_res;
              hold_des            <= ex_des;
              hold_register_write <= ex_register_write;
              hold_load           <= ~ex_mem_write;
              dmem_req            <= 1'b1;
              dmem_we             <= ex_mem_write;
              dmem_addr           <= {ex_alu_res[31:2], 2'b00};
              dmem_wdata          <= ex_store_data;
              cnt                 <= 8'd0;
              state               <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // The ack is checked first, so it wins over a timeout in the same cycle.
          if (dmem_ack) begin
            dmem_req          <= 1'b0;
            wb_valid          <= 1'b1;
            wb_alu_res        <= hold_alu_res;
            wb_des            <= hold_des;
            wb_register_write <= hold_register_write;
            wb_memoryData     <= hold_load ? dmem_rdata : 32'd0;
            state             <= S_IDLE;
          end else if (cnt == CNT_LAST) begin
            dmem_req      <= 1'b0;
            wb_valid      <= 1'b1;
            wb_alu_res    <= hold_alu_res;
            wb_des        <= hold_des;
            wb_memoryData <= 32'd0;
            mem_err       <= 1'b1;
            state         <= S_IDLE;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage. The driver queues the expected WB record and
// the memory-side plan, which holds the ack delay and read data. A memory responder and a WB
// monitor compare the DUT against these queues.
module tb_mem_access_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_alu_res = '0;
  logic [31:0] ex_store_data = '0;
  logic [31:0] ex_des = '0;
  logic        ex_register_write = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        wb_valid;
  logic [31:0] wb_memoryData;
  logic [31:0] wb_alu_res;
  logic [31:0] wb_des;
  logic        wb_register_write;
  logic        mem_err;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_alu_res(ex_alu_res), .ex_store_data(ex_store_data),
    .ex_des(ex_des), .ex_register_write(ex_register_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_memoryData(wb_memoryData), .wb_alu_res(wb_alu_res),
    .wb_des(wb_des), .wb_register_write(wb_register_write), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] des;
    logic [31:0] md;
    logic        rw;
    logic        err;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    int          d;      // req cycles without ack before ack; d >= TO means never ack
  } plan_t;

  wb_t   exp_q[$];
  plan_t plan_q[$];
  int    compared = 0;
  int    mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one instruction, wait until the stage can take it, and record what must come out.
  task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic [31:0] des,
                       input logic rw, input logic rd, input logic wr,
                       input int d, input logic [31:0] rdata);
    wb_t   e;
    plan_t p;
    logic  misal;
    int    n;
    ex_valid = 1'b1; ex_alu_res = a; ex_store_data = sd; ex_des = des;
    ex_register_write = rw; ex_mem_read = rd; ex_mem_write = wr;
    n = 0;
    @(negedge clk);
    while (stall_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", {31'd0, stall_out}, 32'd0);
    e.alu = a; e.des = des; e.md = 32'd0; e.rw = rw; e.err = 1'b0;
    if (rd || wr) begin
`ifdef MEM_MISALIGN_TRAP_EN
      misal = (a[1:0] != 2'b00);
`else
      misal = 1'b0;
`endif
      if (misal) begin
        e.rw = 1'b0; e.err = 1'b1;
      end else begin
        p.addr = a & 32'hFFFF_FFFC; p.wdata = sd; p.we = wr; p.rdata = rdata; p.d = d;
        plan_q.push_back(p);
        if (d >= TO) begin
          e.rw = 1'b0; e.err = 1'b1;
        end else if (!wr) begin
          e.md = rdata;
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  // Memory responder: serves each request according to its plan and checks the request side.
  plan_t cur;
  int    rcnt = 0;
  logic  active = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0; rcnt = 0; dmem_ack = 1'b0;
    end else begin
      check("stall_eq_req", {31'd0, stall_out}, {31'd0, dmem_req});
      if (dmem_req) begin
        if (!active) begin
          active = 1'b1; rcnt = 0;
          if (plan_q.size() == 0) begin
            check("unexpected_req", 32'd1, 32'd0);
            cur.addr = dmem_addr; cur.wdata = dmem_wdata; cur.we = dmem_we;
            cur.rdata = 32'd0; cur.d = 0;
          end else begin
            cur = plan_q.pop_front();
          end
        end
        check("dmem_addr", dmem_addr, cur.addr);
        check("dmem_we", {31'd0, dmem_we}, {31'd0, cur.we});
        if (cur.we) check("dmem_wdata", dmem_wdata, cur.wdata);
        dmem_ack = (rcnt == cur.d);
        dmem_rdata = dmem_ack ? cur.rdata : $urandom;
        rcnt++;
      end else begin
        if (active) begin
          check("req_cycles", rcnt, (cur.d >= TO) ? TO : cur.d + 1);
          active = 1'b0;
        end
        // Spurious acks while idle must be ignored.
        dmem_ack = ($urandom_range(0, 3) == 0);
        dmem_rdata = $urandom;
      end
    end
  end

  // WB monitor.
  always @(negedge clk) begin
    wb_t e;
    if (rst_n) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wb", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wb_alu_res", wb_alu_res, e.alu);
          check("wb_des", wb_des, e.des);
          check("wb_memoryData", wb_memoryData, e.md);
          check("wb_register_write", {31'd0, wb_register_write}, {31'd0, e.rw});
          check("mem_err", {31'd0, mem_err}, {31'd0, e.err});
        end
      end else begin
        check("bubble_flags", {30'd0, wb_register_write, mem_err}, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          kind;
    #17;
    check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst_stall", {31'd0, stall_out}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_wb_alu_res", wb_alu_res, 32'd0);
    check("rst_mem_err", {31'd0, mem_err}, 32'd0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain ALU op: WB is valid one cycle later.
    issue(32'h1234, 32'h0, 32'd5, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    check("alu_latency_valid", {31'd0, wb_valid}, 32'd1);
    check("alu_latency_res", wb_alu_res, 32'h1234);
    // Load with a 3-cycle ack delay.
    issue(32'h100, 32'h0, 32'd7, 1'b1, 1'b1, 1'b0, 3, 32'hDEADBEEF);
    // Store, then an ALU op that is held by the stall.
    issue(32'h200, 32'hA5A5A5A5, 32'd8, 1'b0, 1'b0, 1'b1, 1, 32'h0);
    issue(32'h42, 32'h0, 32'd9, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    // Timeout, ack on the final cycle, ack in the first cycle, and read+write.
    issue(32'h300, 32'h0, 32'd10, 1'b1, 1'b1, 1'b0, TO + 5, 32'h11);
    issue(32'h304, 32'h0, 32'd11, 1'b1, 1'b1, 1'b0, TO - 1, 32'h22);
    issue(32'h308, 32'h0, 32'd12, 1'b1, 1'b1, 1'b0, 0, 32'h33);
    issue(32'h30C, 32'h77, 32'd13, 1'b1, 1'b1, 1'b1, 1, 32'h44);
    // Misaligned load.
    issue(32'h103, 32'h0, 32'd14, 1'b1, 1'b1, 1'b0, 1, 32'h55);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 4);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if (kind == 4) begin
        ex_valid = 1'b0; ex_alu_res = a; ex_mem_read = 1'b1; ex_register_write = 1'b1;
        @(posedge clk); #1;
      end else begin
        issue(a, $urandom, $urandom, 1'($urandom), kind == 1 || kind == 3,
              kind == 2 || kind == 3, $urandom_range(0, TO + 1), $urandom);
      end
    end

    // Reset in the middle of a transaction.
    issue(32'h400, 32'h0, 32'd20, 1'b1, 1'b1, 1'b0, 50, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("midrst_stall", {31'd0, stall_out}, 32'd0);
    check("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    exp_q.delete();
    plan_q.delete();
    @(negedge clk); @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(32'h5678, 32'h0, 32'd6, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    check("post_rst_valid", {31'd0, wb_valid}, 32'd1);
    check("post_rst_alu", wb_alu_res, 32'h5678);

    repeat (30) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("plan_q_drained", plan_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
